// File: rtl/bk_chunked_add_sequencer.sv
// bk_chunked_add_sequencer: drives one external CHUNK-bit Brent-Kung adder over a
// WIDTH-bit add, LSB chunk first, chaining carry-out into the next chunk's C_0.
`default_nettype none

module bk_chunked_add_sequencer #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic [CHUNK-1:0] add_a,
  output logic [CHUNK-1:0] add_b,
  output logic             add_c0,
  input  logic [CHUNK-1:0] add_s,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             ovf_out,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef logic [NCHUNK-1:0][CHUNK-1:0] chunks_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  chunks_t          a_q, a_d;
  chunks_t          b_q, b_d;
  chunks_t          part_q, part_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_out_q, sum_out_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic    accept;
  chunks_t final_sum;
  logic    msb_a;
  logic    msb_b;

  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Full result as it will look after the last pass: lower chunks already
  // captured, top chunk taken straight from the adder this cycle.
  always_comb begin
    final_sum             = part_q;
    final_sum[NCHUNK-1]   = add_s;
  end

  assign msb_a = a_q[NCHUNK-1][CHUNK-1];
  assign msb_b = b_q[NCHUNK-1][CHUNK-1];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    part_d    = part_q;
    carry_d   = carry_q;
    sum_out_d = sum_out_q;
    c_out_d   = c_out_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = c_in;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        part_d[idx_q] = add_s;
        carry_d       = add_cout;
        if (idx_q == LAST_IDX) begin
          idx_d     = '0;
          state_d   = S_DONE;
          sum_out_d = final_sum;
          c_out_d   = add_cout;
          ovf_d     = (msb_a == msb_b) && (add_s[CHUNK-1] != msb_a);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            a_d     = a_in;
            b_d     = b_in;
            carry_d = c_in;
            idx_d   = '0;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      part_q    <= '0;
      carry_q   <= 1'b0;
      sum_out_q <= '0;
      c_out_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      part_q    <= part_d;
      carry_q   <= carry_d;
      sum_out_q <= sum_out_d;
      c_out_q   <= c_out_d;
      ovf_q     <= ovf_d;
    end
  end

  // Adder inputs are forced quiet outside RUN so the shared adder sees no stale operands.
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_c0 = 1'b0;
    if (state_q == S_RUN) begin
      add_a  = a_q[idx_q];
      add_b  = b_q[idx_q];
      add_c0 = carry_q;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum_out   = sum_out_q;
  assign c_out     = c_out_q;
  assign ovf_out   = ovf_q;

endmodule

`default_nettype wire
